// File: rtl/egress_pop_scheduler.sv
// Weighted round-robin pop/push sequencer between the four middle FIFOs and the four output FIFOs.
// Define SCHED_WEIGHT_EN for weighted bursts; without it every class gets a burst of one (pure round robin).
module egress_pop_scheduler #(
  parameter int WEIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            empty,
  input  logic [3:0]            almost_full,
  input  logic [4*WEIGHT_W-1:0] weight,
  output logic [3:0]            pop,
  output logic [3:0]            push,
  output logic [1:0]            grant_idx,
  output logic                  grant_valid,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t     state_q, state_d;
  logic [1:0] cur_q, cur_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] push_q, push_d;

  logic [3:0] eligible;
  logic [1:0] search_start;
  logic [1:0] cand;
  logic [1:0] found_idx;
  logic       found;
  logic       continue_burst;
  logic [1:0] gnt;
  logic       gnt_valid;

  // Gating with reset keeps pop quiet while reset is held, so no push can follow it.
  assign eligible = ~empty & ~almost_full & {4{enable & ~reset}};

`ifdef SCHED_WEIGHT_EN
  logic [WEIGHT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [WEIGHT_W-1:0] w_raw;
  logic [WEIGHT_W-1:0] w_eff;

  assign w_raw = weight[int'(cur_q)*WEIGHT_W +: WEIGHT_W];
  assign w_eff = (w_raw == '0) ? WEIGHT_W'(1) : w_raw;
  assign continue_burst = (state_q == BURST) && eligible[cur_q] && (burst_cnt_q < w_eff);
`else
  logic unused_weight;

  assign unused_weight = ^weight;
  assign continue_burst = 1'b0;
`endif

  // Rotating first-eligible search; wraps naturally in 2 bits.
  assign search_start = (state_q == BURST) ? cur_q + 2'd1 : ptr_q;

  always_comb begin
    found     = 1'b0;
    found_idx = cur_q;
    cand      = search_start;
    for (int i = 0; i < 4; i++) begin
      cand = search_start + 2'(i);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        found_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    ptr_d     = ptr_q;
    gnt       = cur_q;
    gnt_valid = 1'b0;
`ifdef SCHED_WEIGHT_EN
    burst_cnt_d = burst_cnt_q;
`endif
    if (!enable) begin
      state_d = IDLE;
`ifdef SCHED_WEIGHT_EN
      burst_cnt_d = '0;
`endif
    end else if (continue_burst) begin
      gnt_valid = 1'b1;
`ifdef SCHED_WEIGHT_EN
      burst_cnt_d = burst_cnt_q + 1'b1;
`endif
    end else if (found) begin
      gnt       = found_idx;
      gnt_valid = 1'b1;
      cur_d     = found_idx;
      state_d   = BURST;
`ifdef SCHED_WEIGHT_EN
      burst_cnt_d = WEIGHT_W'(1);
`endif
    end else begin
      state_d = IDLE;
      if (state_q == BURST) begin
        ptr_d = cur_q + 2'd1;
      end
`ifdef SCHED_WEIGHT_EN
      burst_cnt_d = '0;
`endif
    end
  end

  assign pop         = gnt_valid ? (4'b0001 << gnt) : 4'b0000;
  assign push_d      = pop;
  assign grant_valid = gnt_valid;
  assign grant_idx   = gnt_valid ? gnt : cur_q;
  assign push        = push_q;
  assign busy        = (state_q == BURST) || (push_q != 4'b0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= 2'd0;
      ptr_q   <= 2'd0;
      push_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      push_q  <= push_d;
    end
  end

`ifdef SCHED_WEIGHT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

endmodule

// File: doc/egress_pop_scheduler.md
# egress_pop_scheduler

Weighted round-robin scheduler that moves entries from the four per-class middle FIFOs to the four per-class output FIFOs of the transaction layer. It replaces the fixed-priority pop/push sequencing between those FIFO banks. Each cycle it issues at most one pop on an eligible source FIFO, then the matching push one cycle later. It honours empty on the source side and almost_full on the destination side.

## Interface
Parameters:
- WEIGHT_W, 3, width of each per-class burst weight.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- enable  input  1  scheduling permitted; driven high by the top-level state machine in its active state.
- empty  input  4  empty flags of middle FIFOs P0..P3.
- almost_full  input  4  almost_full flags of output FIFOs P0..P3.
- weight  input  4*WEIGHT_W  burst weight per class; class i in bits [i*WEIGHT_W +: WEIGHT_W].
- pop  output  4  one-hot/zero pop strobe to middle FIFOs (Mealy, same cycle as decision).
- push  output  4  one-hot/zero push strobe to output FIFOs (registered).
- grant_idx  output  2  class granted in current cycle; holds last value when no grant.
- grant_valid  output  1  high when pop is non-zero.
- busy  output  1  high in BURST state or when push is non-zero.

## Operation
- Class i is eligible when empty[i]==0 and almost_full[i]==0 and enable==1.
- Registered state: FSM {IDLE, BURST}, cur[1:0], ptr[1:0], burst_cnt[WEIGHT_W-1:0], push register.
- Effective weight w_i = weight_i, except 0 is treated as 1.
- Grant selection, evaluated combinationally each cycle:
  - If state==BURST, cur is eligible and burst_cnt < w_cur: grant cur. Then burst_cnt <= burst_cnt+1.
  - Otherwise search for the first eligible class starting at (state==BURST ? cur+1 : ptr), wrapping mod 4.
  - If one is found: grant it, cur <= it, burst_cnt <= 1, state <= BURST.
  - If none is found: no grant, state <= IDLE, ptr <= cur+1 when leaving BURST, burst_cnt <= 0.
  - When a burst ends by weight exhaustion, the next search starts at cur+1, even if cur is still eligible. This gives fairness.
- A grant of class k drives pop[k]=1 and grant_valid=1 in that cycle; push[k] is asserted in the next cycle.
- Pending push always completes, even if enable falls, almost_full[k] rises, or empty changes. The almost_full margin absorbs it.
- enable==0: pop=0, state <= IDLE, burst_cnt <= 0; ptr retained.
- Arithmetic: ptr/cur wrap 3->0; burst_cnt never exceeds w_cur (max 7), so no overflow.

## Timing
- Reset values: pop=0, push=0, grant_idx=0, grant_valid=0, busy=0, state=IDLE, ptr=0, cur=0, burst_cnt=0.
- Reset is synchronous and dominates: a pending push is dropped, and no push occurs in the cycle after reset.
- Pop-to-push latency: exactly 1 cycle. Push data is the middle FIFO data_out presented after the pop edge.
- Throughput: one transfer per cycle while any class is eligible. There is no bubble on class switch.
- Flag timing: empty/almost_full are used in the same cycle. A FIFO holding one entry gets one pop; its empty flag updates before the next decision.
- Simultaneous events: weight changes take effect on the next comparison. A weight lowered below burst_cnt ends the burst at once.

## Configuration
- SCHED_WEIGHT_EN defined: weighted bursts as above.
- SCHED_WEIGHT_EN undefined: the weight port is ignored, every w_i=1, giving pure round robin. burst_cnt logic is removed; the port remains for pin compatibility.

## Test plan
- Reset: hold reset 2 cycles with all FIFOs non-empty -> pop=0, push=0, busy=0; the first grant after release is class 0.
- Round robin: all eligible, weights all 1 -> pop sequence 1,2,4,8,1... on consecutive cycles; push is the same sequence delayed 1 cycle.
- Weighted: weights {3,1,0,2}, all eligible -> grant order 0,0,0,1,2,3,3,0,... (weight 0 behaves as 1).
- Backpressure: almost_full[1] high during a class-1 burst -> class 1 is skipped in the next cycle, the push from the last pop still fires, and class 1 resumes when the flag clears.
- Empty drain: only class 2 holds 2 entries -> pop[2] is high exactly 2 cycles, then state returns to IDLE and ptr=3.
- Enable drop: deassert enable the cycle after a pop of class 3 -> push[3]=1 once, then pop=0 and busy=0.
